game_flow_ctrl: RTL and testbench

- Parametrised game-progression controller. Tracks level, world and lives, and drives the screen select and the player-enable gating.
- Sits between the input decoders (buttons/keyboard), PlayerObject (player_dead) and Scrolls (level_complete). Feeds Scrolls, Obstacles, the screen mux and the life LEDs.
- New features: button edge detection, pause, bonus-life award with saturation, and a timed respawn grace period.

---
 rtl/game_flow_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-progression controller.
// Tracks level/world/lives and drives the screen select and the player gating.
//
// State table:
//   state      | meaning
//   S_INIT     | title screen, counters loaded with start values
//   S_PLAY     | game running
//   S_PAUSE    | game frozen by the player
//   S_DIE      | one cycle, take a life
//   S_RESPAWN  | grace period after a death, timed
//   S_ADVANCE  | one cycle, step level/world and award any bonus life
//   S_LEVEL_SHOW | level-up screen, waits for continue
//   S_WORLD_SHOW | world-up screen, waits for continue
//   S_WIN      | win screen, waits for continue
//   S_LOSE     | lose screen, waits for continue
//   S_RESET    | one cycle, pulses resetSelect to downstream objects
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   continue_btn/start_btn/pause_btn level-sensitive buttons (edge-detected here)
//   player_dead, level_complete     game events
//   level, world, lives             1-based level/world, remaining lives
//   screen                          0 blank,1 ready,2 lose,3 win,4 lvl-up,5 world-up,6 paused
//   playerDisable                   1 = player movement frozen
//   resetSelect                     one-cycle pulse resetting game objects
module game_flow_ctrl #(
  parameter int LEVELS_PER_WORLD = 3,
  parameter int WORLDS           = 6,
  parameter int START_LIVES      = 7,
  parameter int MAX_LIVES        = 7,
  parameter int BONUS_EVERY      = 4,
  parameter int RESPAWN_CYC      = 25000000,
  localparam int LVL_W = $clog2(LEVELS_PER_WORLD + 1),
  localparam int WLD_W = $clog2(WORLDS + 1),
  localparam int LIV_W = $clog2(MAX_LIVES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             continue_btn,
  input  logic             start_btn,
  input  logic             pause_btn,
  input  logic             player_dead,
  input  logic             level_complete,
  output logic [LVL_W-1:0] level,
  output logic [WLD_W-1:0] world,
  output logic [LIV_W-1:0] lives,
  output logic [2:0]       screen,
  output logic             playerDisable,
  output logic             resetSelect
);

  localparam int TMR_W = $clog2(RESPAWN_CYC + 1);
  localparam int BON_W = (BONUS_EVERY > 0) ? $clog2(BONUS_EVERY + 1) : 1;

  typedef enum logic [3:0] {
    S_INIT, S_PLAY, S_PAUSE, S_DIE, S_RESPAWN, S_ADVANCE,
    S_LEVEL_SHOW, S_WORLD_SHOW, S_WIN, S_LOSE, S_RESET
  } state_t;

  state_t           state_q, state_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic [WLD_W-1:0] world_nxt;
  logic [LIV_W-1:0] lives_nxt, lives_dec;
  logic [BON_W-1:0] bonus_q, bonus_nxt;
  logic [TMR_W-1:0] timer_q, timer_nxt;
  logic             cont_q, start_q, pause_q;
  logic             cont_e, start_e, pause_e;
  logic             won;

  assign cont_e  = continue_btn & ~cont_q;
  assign start_e = start_btn & ~start_q;
  assign pause_e = pause_btn & ~pause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      level   <= LVL_W'(1);
      world   <= WLD_W'(1);
      lives   <= LIV_W'(START_LIVES);
      bonus_q <= '0;
      timer_q <= '0;
      // Loaded high so a button held through reset needs a fresh press.
      cont_q  <= 1'b1;
      start_q <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      state_q <= state_nxt;
      level   <= level_nxt;
      world   <= world_nxt;
      lives   <= lives_nxt;
      bonus_q <= bonus_nxt;
      timer_q <= timer_nxt;
      cont_q  <= continue_btn;
      start_q <= start_btn;
      pause_q <= pause_btn;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    level_nxt     = level;
    world_nxt     = world;
    lives_nxt     = lives;
    bonus_nxt     = bonus_q;
    timer_nxt     = timer_q;
    lives_dec     = (lives != '0) ? lives - LIV_W'(1) : '0;
    won           = 1'b0;
    screen        = 3'd0;
    playerDisable = 1'b1;
    resetSelect   = 1'b0;

    case (state_q)
      S_INIT: begin
        screen    = 3'd1;
        level_nxt = LVL_W'(1);
        world_nxt = WLD_W'(1);
        lives_nxt = LIV_W'(START_LIVES);
        bonus_nxt = '0;
        if (cont_e || start_e) state_nxt = S_PLAY;
      end
      S_PLAY: begin
        playerDisable = 1'b0;
        // Death wins over completion; a pause edge alongside either is dropped.
        if (player_dead)         state_nxt = S_DIE;
        else if (level_complete) state_nxt = S_ADVANCE;
        else if (pause_e)        state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        screen = 3'd6;
        if (pause_e || cont_e) state_nxt = S_PLAY;
      end
      S_DIE: begin
        playerDisable = 1'b0;
        lives_nxt     = lives_dec;
        timer_nxt     = '0;
        state_nxt     = (lives_dec == '0) ? S_LOSE : S_RESPAWN;
      end
      S_RESPAWN: begin
        playerDisable = 1'b0;
        if (timer_q != TMR_W'(RESPAWN_CYC)) timer_nxt = timer_q + TMR_W'(1);
        // Leaving only on player_dead=0 keeps a held death from re-triggering.
        if (!player_dead && timer_q == TMR_W'(RESPAWN_CYC)) state_nxt = S_PLAY;
      end
      S_ADVANCE: begin
        if (level < LVL_W'(LEVELS_PER_WORLD)) begin
          level_nxt = level + LVL_W'(1);
          state_nxt = S_LEVEL_SHOW;
        end else if (world < WLD_W'(WORLDS)) begin
          world_nxt = world + WLD_W'(1);
          level_nxt = LVL_W'(1);
          state_nxt = S_WORLD_SHOW;
        end else begin
          won       = 1'b1;
          state_nxt = S_WIN;
        end
        if (!won && BONUS_EVERY != 0) begin
          if (bonus_q == BON_W'(BONUS_EVERY - 1)) begin
            bonus_nxt = '0;
            if (lives < LIV_W'(MAX_LIVES)) lives_nxt = lives + LIV_W'(1);
          end else begin
            bonus_nxt = bonus_q + BON_W'(1);
          end
        end
      end
      S_LEVEL_SHOW: begin
        screen = 3'd4;
        if (cont_e) state_nxt = S_PLAY;
      end
      S_WORLD_SHOW: begin
        screen = 3'd5;
        if (cont_e) state_nxt = S_PLAY;
      end
      S_WIN: begin
        screen = 3'd3;
        if (cont_e) state_nxt = S_RESET;
      end
      S_LOSE: begin
        screen = 3'd2;
        if (cont_e) state_nxt = S_RESET;
      end
      S_RESET: begin
        resetSelect = 1'b1;
        // Preloaded here so INIT shows start values from its first cycle.
        level_nxt   = LVL_W'(1);
        world_nxt   = WLD_W'(1);
        lives_nxt   = LIV_W'(START_LIVES);
        bonus_nxt   = '0;
        state_nxt   = S_INIT;
      end
      default: state_nxt = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  localparam int L = 2, W = 2, ST = 3, MX = 4, BN = 3, RC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic continue_btn = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
  logic player_dead = 1'b0, level_complete = 1'b0;
  logic [1:0] level, world, level2, world2;
  logic [2:0] lives, lives2, screen, screen2;
  logic playerDisable, resetSelect, playerDisable2, resetSelect2;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  game_flow_ctrl #(.LEVELS_PER_WORLD(L), .WORLDS(W), .START_LIVES(ST), .MAX_LIVES(MX),
                   .BONUS_EVERY(BN), .RESPAWN_CYC(RC)) dut (
    .clk(clk), .rst(rst), .continue_btn(continue_btn), .start_btn(start_btn),
    .pause_btn(pause_btn), .player_dead(player_dead), .level_complete(level_complete),
    .level(level), .world(world), .lives(lives), .screen(screen),
    .playerDisable(playerDisable), .resetSelect(resetSelect));

  // Second instance already at the lives ceiling, awarding a bonus every level.
  game_flow_ctrl #(.LEVELS_PER_WORLD(L), .WORLDS(W), .START_LIVES(4), .MAX_LIVES(4),
                   .BONUS_EVERY(1), .RESPAWN_CYC(RC)) dut_sat (
    .clk(clk), .rst(rst), .continue_btn(continue_btn), .start_btn(start_btn),
    .pause_btn(pause_btn), .player_dead(player_dead), .level_complete(level_complete),
    .level(level2), .world(world2), .lives(lives2), .screen(screen2),
    .playerDisable(playerDisable2), .resetSelect(resetSelect2));

  // Reference model: progress counted as completed levels; modes named by what the player sees.
  localparam int M_TITLE = 0, M_RUN = 1, M_HOLD = 2, M_DYING = 3, M_RECOVER = 4, M_ADV = 5,
                 M_LSHOW = 6, M_WSHOW = 7, M_WON = 8, M_LOST = 9, M_RST = 10;
  int m_mode, m_prog, m_lives, m_nb, m_k;
  logic pc, ps, pp;

  function automatic int pk(int scr, int pd, int rs, int lv, int wd, int li);
    return scr * 100000 + pd * 10000 + rs * 1000 + lv * 100 + wd * 10 + li;
  endfunction

  function automatic int model_out();
    int scr;
    int pd;
    case (m_mode)
      M_TITLE: scr = 1;
      M_HOLD:  scr = 6;
      M_LSHOW: scr = 4;
      M_WSHOW: scr = 5;
      M_WON:   scr = 3;
      M_LOST:  scr = 2;
      default: scr = 0;
    endcase
    pd = (m_mode == M_RUN || m_mode == M_DYING || m_mode == M_RECOVER) ? 0 : 1;
    return pk(scr, pd, (m_mode == M_RST) ? 1 : 0, m_prog % L + 1, m_prog / L + 1, m_lives);
  endfunction

  task automatic model_step(input logic r, c, s, p, d, lc);
    logic ce, se, pe;
    if (r) begin
      m_mode = M_TITLE; m_prog = 0; m_lives = ST; m_nb = 0; m_k = 0;
      pc = 1'b1; ps = 1'b1; pp = 1'b1;
    end else begin
      ce = c & ~pc; se = s & ~ps; pe = p & ~pp;
      case (m_mode)
        M_TITLE: begin
          m_prog = 0; m_lives = ST; m_nb = 0;
          if (ce || se) m_mode = M_RUN;
        end
        M_RUN: begin
          if (d) m_mode = M_DYING;
          else if (lc) m_mode = M_ADV;
          else if (pe) m_mode = M_HOLD;
        end
        M_HOLD: if (pe || ce) m_mode = M_RUN;
        M_DYING: begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_k = 0;
          m_mode = (m_lives == 0) ? M_LOST : M_RECOVER;
        end
        M_RECOVER: begin
          if (m_k >= RC && !d) m_mode = M_RUN;
          m_k++;
        end
        M_ADV: begin
          if (m_prog == L * W - 1) m_mode = M_WON;
          else begin
            m_prog++;
            m_mode = (m_prog % L == 0) ? M_WSHOW : M_LSHOW;
            m_nb++;
            if (m_nb == BN) begin
              m_nb = 0;
              m_lives = (m_lives + 1 > MX) ? MX : m_lives + 1;
            end
          end
        end
        M_LSHOW, M_WSHOW: if (ce) m_mode = M_RUN;
        M_WON, M_LOST:    if (ce) m_mode = M_RST;
        default: begin
          m_prog = 0; m_lives = ST; m_nb = 0; m_mode = M_TITLE;
        end
      endcase
      pc = c; ps = s; pp = p;
    end
  endtask

  function automatic int dut_out();
    return pk(int'(screen), int'(playerDisable), int'(resetSelect),
              int'(level), int'(world), int'(lives));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_n, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, compare with the model after the rising edge.
  task automatic tick(input logic r, c, s, p, d, lc);
    @(negedge clk);
    rst = r; continue_btn = c; start_btn = s; pause_btn = p;
    player_dead = d; level_complete = lc;
    model_step(r, c, s, p, d, lc);
    @(posedge clk);
    #1;
    cyc_n++;
    chk("model", dut_out(), model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic r, c, s, p, d, lc;
    int   exp;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(logic r, c, s, p, d, lc, int scr, pd, rs, lv, wd, li);
    vec_t v;
    v.r = r; v.c = c; v.s = s; v.p = p; v.d = d; v.lc = lc;
    v.exp = pk(scr, pd, rs, lv, wd, li);
    return v;
  endfunction

  initial begin
    //             r  c  s  p  d  lc   scr pd rs lv wd li
    tbl[0]  = mk(1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 1, 3);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0,  1, 1, 0, 1, 1, 3);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 1, 3);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 3);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 1, 3);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,  4, 1, 0, 2, 1, 3);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 2, 1, 3);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 2, 1, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0,  5, 1, 0, 1, 2, 3);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 2, 3);
    tbl[10] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 2, 3);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,  4, 1, 0, 2, 2, 4);
    tbl[12] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 2, 2, 4);
    tbl[13] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 2, 2, 4);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,  3, 1, 0, 2, 2, 4);
    tbl[15] = mk(0, 1, 0, 0, 0, 0,  0, 1, 1, 2, 2, 4);
    tbl[16] = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 1, 3);
    tbl[17] = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 1, 3);

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].r, tbl[i].c, tbl[i].s, tbl[i].p, tbl[i].d, tbl[i].lc);
      chk($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
    end

    // Held death: one decrement, player enabled throughout, exact respawn exit.
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0, 1, 0);
      chk("dead_hold_pd", int'(playerDisable), 0);
    end
    chk("dead_hold_lives", int'(lives), 2);
    tick(0, 0, 0, 0, 0, 1);
    chk("respawn_exit_pd", int'(playerDisable), 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("advance_after_respawn_pd", int'(playerDisable), 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("lvl_show_screen", int'(screen), 4);
    chk("lvl_show_level", int'(level), 2);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Two more deaths -> lose with level/world untouched.
    tick(0, 0, 0, 0, 1, 0);
    idle(7);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("lose_screen", int'(screen), 2);
    chk("lose_lives", int'(lives), 0);
    chk("lose_level", int'(level), 2);
    chk("lose_world", int'(world), 1);
    tick(0, 1, 0, 0, 0, 0);
    chk("lose_reset_pulse", int'(resetSelect), 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("lose_reset_end", int'(resetSelect), 0);
    chk("lose_init_lives", int'(lives), 3);

    // Pause ignores events; pause+continue together resumes once.
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("pause_screen", int'(screen), 6);
    chk("pause_pd", int'(playerDisable), 1);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("pause_ignore", dut_out(), pk(6, 1, 0, 1, 1, 3));
    tick(0, 0, 0, 1, 0, 0);
    chk("unpause", dut_out(), pk(0, 0, 0, 1, 1, 3));
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 0, 0);
    tick(0, 1, 0, 1, 0, 0);
    chk("pause_cont_once", int'(screen), 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("bonus_sat_lives", int'(lives2), 4);
    chk("bonus_sat_level", int'(level2), 2);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Death, completion and pause edge together -> death path only.
    tick(0, 0, 0, 1, 1, 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("simul_state", dut_out(), pk(0, 0, 0, 2, 1, 2));
    idle(6);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("world_show", dut_out(), pk(5, 1, 0, 1, 2, 2));
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("lvl_show_bonus", dut_out(), pk(4, 1, 0, 2, 2, 3));
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_in_lvl_show", dut_out(), pk(1, 1, 0, 1, 1, 3));

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
